spi_dual_arbiter: RTL and testbench

// - Shares one SPI shift engine between two byte-stream requesters: port 0 = flash, port 1 = g-sensor.
// - Sits between the processor-side SPI clients and the spi_flash_* / spi_g_sen_* pins.
// - Arbitrates whole transactions (SS_n framing) round-robin, generates SPI mode 0 timing,
//   and returns each received byte to the requester that owns the grant.

---
 rtl/spi_dual_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_dual_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dual_arbiter.sv
// Shares one SPI mode-0 shift engine between a flash and a g-sensor requester, whole SS_n frames round-robin.
// Latency: SS_n falls one cycle after a request is seen; each byte takes 16*CLK_DIV cycles plus one LOAD cycle.
// Backpressure: rN_ready only in LOAD for the granted port; rvalid cannot be stalled; a waiting port is never touched.
module spi_dual_arbiter #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       clk_in_clk,
    input  logic       reset_reset_n,
    input  logic       r0_valid,
    input  logic [7:0] r0_data,
    input  logic       r0_last,
    output logic       r0_ready,
    output logic       r0_rvalid,
    output logic [7:0] r0_rdata,
    input  logic       r1_valid,
    input  logic [7:0] r1_data,
    input  logic       r1_last,
    output logic       r1_ready,
    output logic       r1_rvalid,
    output logic [7:0] r1_rdata,
    output logic       spi_flash_SCLK,
    output logic       spi_flash_MOSI,
    output logic       spi_flash_SS_n,
    input  logic       spi_flash_MISO,
    output logic       spi_g_sen_SCLK,
    output logic       spi_g_sen_MOSI,
    output logic       spi_g_sen_SS_n,
    input  logic       spi_g_sen_MISO,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_grant, w_grant_nxt;
    logic        r_rr_last;
    logic [15:0] r_cnt;
    logic        r_sclk, r_cs, r_last_byte;
    logic [3:0]  r_edge;
    logic [7:0]  r_tx, r_rx;
    logic [1:0]  r_rvalid;
    logic [7:0]  r_rdata0, r_rdata1;

    logic        w_gvalid, w_glast, w_miso, w_div_tick, w_byte_done;
    logic [7:0]  w_gdata;
    logic        w_fl_sel, w_gs_sel;

    assign w_gvalid    = r_grant ? r1_valid : r0_valid;
    assign w_gdata     = r_grant ? r1_data  : r0_data;
    assign w_glast     = r_grant ? r1_last  : r0_last;
    assign w_miso      = r_grant ? spi_g_sen_MISO : spi_flash_MISO;
    assign w_div_tick  = (r_cnt == 16'(CLK_DIV - 1));
    // Edge 15 is the 8th falling edge: the byte is complete there.
    assign w_byte_done = (r_state == S_SHIFT) && w_div_tick && r_sclk && (r_edge == 4'd15);

    always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (r0_valid || r1_valid) begin
                    w_state_nxt = S_SETUP;
                    if (r0_valid && r1_valid) w_grant_nxt = ~r_rr_last;
                    else                      w_grant_nxt = r1_valid;
                end
            end
            S_SETUP: if (r_cnt == 16'(CS_SETUP - 1)) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_gvalid) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_byte_done) w_state_nxt = r_last_byte ? S_HOLD : S_LOAD;
            S_HOLD:  if (r_cnt == 16'(CS_HOLD - 1)) w_state_nxt = S_GAP;
            S_GAP:   if (r_cnt == 16'(CS_GAP - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_grant     <= 1'b0;
            r_rr_last   <= 1'b1;
            r_cnt       <= '0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b0;
            r_last_byte <= 1'b0;
            r_edge      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rvalid    <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_rvalid <= 2'b00;
            // Chip select follows the next state so SS_n moves on the SETUP and GAP entry edges.
            r_cs     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_GAP);

            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == S_SHIFT && w_div_tick)
                r_cnt <= '0;
            else if (r_state != S_IDLE && r_state != S_LOAD)
                r_cnt <= r_cnt + 16'd1;

            case (r_state)
                S_IDLE: if (w_state_nxt == S_SETUP) r_grant <= w_grant_nxt;
                S_LOAD: begin
                    if (w_gvalid) begin
                        r_tx        <= w_gdata;
                        r_last_byte <= w_glast;
                        r_edge      <= '0;
                        r_sclk      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_div_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 4'd1;
                        if (!r_sclk) begin
                            r_rx <= {r_rx[6:0], w_miso};
                        end else if (r_edge != 4'd15) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end else begin
                            r_rvalid[r_grant] <= 1'b1;
                            if (r_grant) r_rdata1 <= r_rx;
                            else         r_rdata0 <= r_rx;
                        end
                    end
                end
                S_GAP: if (w_state_nxt == S_IDLE) r_rr_last <= r_grant;
                default: ;
            endcase
        end
    end

    assign w_fl_sel       = r_cs && !r_grant;
    assign w_gs_sel       = r_cs && r_grant;
    assign spi_flash_SS_n = ~w_fl_sel;
    assign spi_flash_SCLK = w_fl_sel & r_sclk;
    assign spi_flash_MOSI = w_fl_sel & r_tx[7];
    assign spi_g_sen_SS_n = ~w_gs_sel;
    assign spi_g_sen_SCLK = w_gs_sel & r_sclk;
    assign spi_g_sen_MOSI = w_gs_sel & r_tx[7];

    assign r0_ready  = (r_state == S_LOAD) && !r_grant;
    assign r1_ready  = (r_state == S_LOAD) && r_grant;
    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_dual_arbiter.sv
// Bench for spi_dual_arbiter: SPI slave models plus a queue-based scoreboard per device/requester.
module tb_spi_dual_arbiter;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int TMO      = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0, r0_last = 1'b0, r1_last = 1'b0;
    logic [7:0] r0_data = '0, r1_data = '0;
    logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy;
    logic [7:0] r0_rdata, r1_rdata;
    logic       spi_flash_SCLK, spi_flash_MOSI, spi_flash_SS_n;
    logic       spi_g_sen_SCLK, spi_g_sen_MOSI, spi_g_sen_SS_n;
    logic [1:0] miso = '0;

    spi_dual_arbiter #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .clk_in_clk(clk), .reset_reset_n(rst_n),
        .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .spi_flash_SCLK(spi_flash_SCLK), .spi_flash_MOSI(spi_flash_MOSI),
        .spi_flash_SS_n(spi_flash_SS_n), .spi_flash_MISO(miso[0]),
        .spi_g_sen_SCLK(spi_g_sen_SCLK), .spi_g_sen_MOSI(spi_g_sen_MOSI),
        .spi_g_sen_SS_n(spi_g_sen_SS_n), .spi_g_sen_MISO(miso[1]),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [1:0] ss_v, sclk_v, mosi_v, ready_v, valid_v, rvalid_v;
    logic [7:0] rdata_v [2];
    assign ss_v     = {spi_g_sen_SS_n, spi_flash_SS_n};
    assign sclk_v   = {spi_g_sen_SCLK, spi_flash_SCLK};
    assign mosi_v   = {spi_g_sen_MOSI, spi_flash_MOSI};
    assign ready_v  = {r1_ready, r0_ready};
    assign valid_v  = {r1_valid, r0_valid};
    assign rvalid_v = {r1_rvalid, r0_rvalid};
    assign rdata_v[0] = r0_rdata;
    assign rdata_v[1] = r1_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-port queues of what the device must see and what the requester must get back.
    logic [7:0] exp_tx [2][$];
    logic [7:0] resp_q [2][$];
    logic [7:0] exp_rx [2][$];
    int         exp_len [2][$];
    int         frame_order [$];

    logic [1:0] p_ss = 2'b11, p_sclk = 2'b00, p_rvalid = 2'b00;
    int         bitcnt [2], nbytes [2], flen [2], hi_cnt [2], setup_cnt [2];
    logic       seen_rise [2];
    logic [7:0] cap [2], cur_resp [2];
    int         gap_cnt = 100;
    int         idle_viol = 0, ready_viol = 0, pulse_viol = 0, stall_viol = 0;
    int         rv_cnt [2] = '{0, 0};
    int         acc_cnt [2] = '{0, 0};
    int         rdy_cyc [2] = '{0, 0};

    always @(negedge clk) begin : mon
        if (!rst_n) begin
            p_ss = 2'b11; p_sclk = 2'b00; p_rvalid = 2'b00; gap_cnt = 100; miso = 2'b00;
            for (int d = 0; d < 2; d++) begin
                exp_tx[d].delete(); resp_q[d].delete(); exp_rx[d].delete(); exp_len[d].delete();
                bitcnt[d] = 0; nbytes[d] = 0; cur_resp[d] = '0;
            end
        end else begin
            if (ss_v == 2'b11) gap_cnt++;
            if (ss_v == 2'b00) idle_viol++;
            for (int d = 0; d < 2; d++) begin
                if (ss_v[d] && (sclk_v[d] || mosi_v[d])) idle_viol++;
                if (ready_v[d] && ss_v[d]) ready_viol++;
                if (ready_v[d]) rdy_cyc[d]++;
                if (ready_v[d] && valid_v[d]) acc_cnt[d]++;
                if (rvalid_v[d]) begin
                    rv_cnt[d]++;
                    if (p_rvalid[d]) pulse_viol++;
                    check("rx_expected", exp_rx[d].size() > 0, 1);
                    if (exp_rx[d].size() > 0) check("rdata", rdata_v[d], exp_rx[d].pop_front());
                end
                p_rvalid[d] = rvalid_v[d];
                if (p_ss[d] && !ss_v[d]) begin
                    frame_order.push_back(d);
                    check("cs_gap", gap_cnt >= CS_GAP, 1);
                    check("frame_expected", exp_len[d].size() > 0, 1);
                    flen[d] = (exp_len[d].size() > 0) ? exp_len[d][0] : 0;
                    nbytes[d] = 0; bitcnt[d] = 0; seen_rise[d] = 1'b0; setup_cnt[d] = 0; hi_cnt[d] = 0;
                    cur_resp[d] = (resp_q[d].size() > 0) ? resp_q[d].pop_front() : 8'h00;
                end
                if (!ss_v[d]) begin
                    if (!seen_rise[d] && !sclk_v[d]) setup_cnt[d]++;
                    if (sclk_v[d]) hi_cnt[d]++;
                    if (sclk_v[d] && !p_sclk[d]) begin
                        if (!seen_rise[d]) check("cs_setup", setup_cnt[d] >= CS_SETUP, 1);
                        seen_rise[d] = 1'b1;
                        cap[d] = {cap[d][6:0], mosi_v[d]};
                        bitcnt[d]++;
                        if (bitcnt[d] == 8) begin
                            bitcnt[d] = 0;
                            nbytes[d]++;
                            check("mosi_expected", exp_tx[d].size() > 0, 1);
                            if (exp_tx[d].size() > 0) check("mosi_byte", cap[d], exp_tx[d].pop_front());
                            cur_resp[d] = (nbytes[d] < flen[d] && resp_q[d].size() > 0) ?
                                          resp_q[d].pop_front() : 8'h00;
                        end
                    end
                    if (!sclk_v[d] && p_sclk[d]) begin
                        check("sclk_high", hi_cnt[d], CLK_DIV);
                        hi_cnt[d] = 0;
                    end
                end
                if (!p_ss[d] && ss_v[d]) begin
                    check("frame_len", nbytes[d], flen[d]);
                    if (exp_len[d].size() > 0) void'(exp_len[d].pop_front());
                    gap_cnt = 0;
                end
                miso[d] = cur_resp[d][3'(7 - bitcnt[d])];
            end
            p_ss   = ss_v;
            p_sclk = sclk_v;
        end
    end

    task automatic set_req(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin r0_valid = v; r0_data = d; r0_last = l; end
        else        begin r1_valid = v; r1_data = d; r1_last = l; end
    endtask

    task automatic expect_txn(input int p, input int len, input logic [0:2][7:0] tx,
                              input logic [0:2][7:0] rsp, input logic [0:2][7:0] rx);
        for (int i = 0; i < len; i++) begin
            exp_tx[p].push_back(tx[i]);
            resp_q[p].push_back(rsp[i]);
            exp_rx[p].push_back(rx[i]);
        end
        exp_len[p].push_back(len);
    endtask

    // Called at a negedge; the stall variant drops valid after each byte until its rx pulse plus 'stall' cycles.
    task automatic send_txn(input int p, input int len, input logic [0:2][7:0] b, input int stall);
        int t;
        for (int i = 0; i < len; i++) begin
            set_req(p, 1'b1, b[i], i == len - 1);
            t = 0;
            while (!ready_v[p] && t < TMO) begin @(negedge clk); t++; end
            check("req_accept", t < TMO, 1);
            @(negedge clk);
            if (i == len - 1 || stall > 0) set_req(p, 1'b0, 8'h00, 1'b0);
            if (stall > 0 && i < len - 1) begin
                t = 0;
                while (!rvalid_v[p] && t < TMO) begin @(negedge clk); t++; end
                check("stall_rvalid", t < TMO, 1);
                repeat (stall) begin
                    @(negedge clk);
                    if (sclk_v[p] || ss_v[p]) stall_viol++;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || r0_valid || r1_valid) && t < TMO) begin @(negedge clk); t++; end
        check("idle_reached", t < TMO, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_port(input int p, input int n, output int total);
        logic [0:2][7:0] bt, rs;
        int len;
        total = 0;
        for (int k = 0; k < n; k++) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < 3; j++) begin
                bt[j] = 8'($urandom);
                rs[j] = 8'($urandom);
            end
            expect_txn(p, len, bt, rs, rs);
            total += len;
            repeat ($urandom_range(0, 15)) @(negedge clk);
            send_txn(p, len, bt, 0);
        end
    endtask

    typedef struct {
        int              port;
        int              len;
        logic [0:2][7:0] tx;
        logic [0:2][7:0] miso;
        logic [0:2][7:0] exp_mosi;
        logic [0:2][7:0] exp_rdata;
    } vec_t;

    vec_t vt [4];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int base, rv0, acc0, rdy0, rises, t, tot0, tot1;
        logic prev_sclk;

        vt[0] = '{port: 0, len: 1, tx: {8'hA5, 8'h00, 8'h00}, miso: {8'h3C, 8'h00, 8'h00},
                  exp_mosi: {8'b1010_0101, 8'h00, 8'h00}, exp_rdata: {8'h3C, 8'h00, 8'h00}};
        vt[1] = '{port: 1, len: 3, tx: {8'h0F, 8'h80, 8'hFF}, miso: {8'h11, 8'h22, 8'hE7},
                  exp_mosi: {8'h0F, 8'h80, 8'hFF}, exp_rdata: {8'h11, 8'h22, 8'hE7}};
        vt[2] = '{port: 0, len: 2, tx: {8'h00, 8'hFF, 8'h00}, miso: {8'hFF, 8'h00, 8'h00},
                  exp_mosi: {8'h00, 8'hFF, 8'h00}, exp_rdata: {8'hFF, 8'h00, 8'h00}};
        vt[3] = '{port: 1, len: 1, tx: {8'h5A, 8'h00, 8'h00}, miso: {8'hC3, 8'h00, 8'h00},
                  exp_mosi: {8'h5A, 8'h00, 8'h00}, exp_rdata: {8'hC3, 8'h00, 8'h00}};

        #1;
        check("reset_pins", {spi_flash_SS_n, spi_g_sen_SS_n, spi_flash_SCLK, spi_g_sen_SCLK,
                             spi_flash_MOSI, spi_g_sen_MOSI, r0_ready, r1_ready, r0_rvalid,
                             r1_rvalid, busy}, 11'b110_0000_0000);
        check("reset_rdata", {r0_rdata, r1_rdata}, 16'h0000);
        do_reset();

        for (int i = 0; i < 4; i++) begin
            expect_txn(vt[i].port, vt[i].len, vt[i].exp_mosi, vt[i].miso, vt[i].exp_rdata);
            base = frame_order.size();
            rv0  = rv_cnt[vt[i].port];
            acc0 = acc_cnt[vt[i].port];
            rdy0 = rdy_cyc[vt[i].port];
            send_txn(vt[i].port, vt[i].len, vt[i].tx, 0);
            wait_idle();
            check("vec_rvalid_pulses", rv_cnt[vt[i].port] - rv0, vt[i].len);
            check("vec_accepts", acc_cnt[vt[i].port] - acc0, vt[i].len);
            check("vec_ready_cycles", rdy_cyc[vt[i].port] - rdy0, vt[i].len);
            check("vec_frames", frame_order.size() - base, 1);
            if (frame_order.size() > base) check("vec_device", frame_order[base], vt[i].port);
        end
        check("idle_pins", idle_viol, 0);
        check("ready_other", ready_viol, 0);

        // Tie straight after reset: flash first, then g-sensor; a second tie goes back to flash.
        do_reset();
        base = frame_order.size();
        expect_txn(0, 1, {8'h11, 8'h00, 8'h00}, {8'h22, 8'h00, 8'h00}, {8'h22, 8'h00, 8'h00});
        expect_txn(1, 2, {8'h33, 8'h44, 8'h00}, {8'h55, 8'h66, 8'h00}, {8'h55, 8'h66, 8'h00});
        fork
            send_txn(0, 1, {8'h11, 8'h00, 8'h00}, 0);
            send_txn(1, 2, {8'h33, 8'h44, 8'h00}, 0);
        join
        wait_idle();
        expect_txn(0, 1, {8'h99, 8'h00, 8'h00}, {8'h98, 8'h00, 8'h00}, {8'h98, 8'h00, 8'h00});
        expect_txn(1, 1, {8'h77, 8'h00, 8'h00}, {8'h76, 8'h00, 8'h00}, {8'h76, 8'h00, 8'h00});
        fork
            send_txn(0, 1, {8'h99, 8'h00, 8'h00}, 0);
            send_txn(1, 1, {8'h77, 8'h00, 8'h00}, 0);
        join
        wait_idle();
        check("tie_frames", frame_order.size() - base, 4);
        if (frame_order.size() - base >= 4) begin
            check("tie1_first", frame_order[base], 0);
            check("tie1_second", frame_order[base + 1], 1);
            check("tie2_first", frame_order[base + 2], 0);
            check("tie2_second", frame_order[base + 3], 1);
        end
        check("tie_ready_other", ready_viol, 0);
        check("tie_idle_pins", idle_viol, 0);

        // Stall between burst bytes with SS_n held low.
        expect_txn(1, 3, {8'hC0, 8'h01, 8'h7E}, {8'hA1, 8'hB2, 8'hC3}, {8'hA1, 8'hB2, 8'hC3});
        base = frame_order.size();
        send_txn(1, 3, {8'hC0, 8'h01, 8'h7E}, 10);
        wait_idle();
        check("stall_pins", stall_viol, 0);
        check("stall_one_frame", frame_order.size() - base, 1);

        // Reset at the 4th SCLK rising edge of a flash byte.
        expect_txn(0, 1, {8'hF0, 8'h00, 8'h00}, {8'h0F, 8'h00, 8'h00}, {8'h0F, 8'h00, 8'h00});
        set_req(0, 1'b1, 8'hF0, 1'b1);
        t = 0;
        while (!r0_ready && t < TMO) begin @(negedge clk); t++; end
        check("rst_req_accept", t < TMO, 1);
        @(negedge clk);
        set_req(0, 1'b0, 8'h00, 1'b0);
        rises = 0; prev_sclk = 1'b0; t = 0;
        while (rises < 4 && t < TMO) begin
            @(posedge clk); #1;
            if (spi_flash_SCLK && !prev_sclk) rises++;
            prev_sclk = spi_flash_SCLK;
            t++;
        end
        check("rst_reach_4th_rise", rises, 4);
        rst_n = 1'b0;
        #1;
        check("rst_async_pins", {spi_flash_SS_n, spi_flash_SCLK, spi_flash_MOSI, busy, r0_ready,
                                 r0_rvalid}, 6'b100_000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rv0 = rv_cnt[0];
        expect_txn(0, 1, {8'h5A, 8'h00, 8'h00}, {8'h96, 8'h00, 8'h00}, {8'h96, 8'h00, 8'h00});
        send_txn(0, 1, {8'h5A, 8'h00, 8'h00}, 0);
        wait_idle();
        check("post_rst_rvalid", rv_cnt[0] - rv0, 1);
        check("post_rst_rdata", r0_rdata, 8'h96);

        // Randomized traffic on both ports against the queue model.
        do_reset();
        rv0 = rv_cnt[0];
        acc0 = rv_cnt[1];
        fork
            rand_port(0, 10, tot0);
            rand_port(1, 10, tot1);
        join
        wait_idle();
        check("rand_rx_port0", rv_cnt[0] - rv0, tot0);
        check("rand_rx_port1", rv_cnt[1] - acc0, tot1);
        check("rand_queues_drained", exp_tx[0].size() + exp_tx[1].size() + exp_rx[0].size() +
                                     exp_rx[1].size() + exp_len[0].size() + exp_len[1].size(), 0);
        check("final_idle_pins", idle_viol, 0);
        check("final_ready_other", ready_viol, 0);
        check("rvalid_one_cycle", pulse_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
